// File: rtl/timer_cmp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_cmp_pkg
//  Description : Shared state encoding, mode codes and threshold reset value
//                for the compare-match timer.
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_cmp_pkg;

    // Run state machine encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_RUN  = 2'd1;
    localparam state_t ST_DONE = 2'd2;

    // Counting modes, latched on start
    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

    // Thresholds come out of reset at all-ones; sliced to DATA_WIDTH by users
    localparam int                     THR_MAX_WIDTH   = 64;
    localparam logic [THR_MAX_WIDTH-1:0] THR_RESET_VALUE = '1;

endpackage : timer_cmp_pkg
`default_nettype wire

// File: rtl/cmp_threshold_bank.sv
`default_nettype none
// ============================================================================
//  Module      : cmp_threshold_bank
//  Description : NUM_CH x DATA_WIDTH threshold register file with one write
//                port, a read mux on the registered channel select and an
//                equality flag against the running count.
//  Revision    : 1.0 - initial release
// ============================================================================
module cmp_threshold_bank
    import timer_cmp_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_CH     = 4,
    localparam int SEL_W      = $clog2(NUM_CH)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_wr_en,
    input  logic [SEL_W-1:0]      i_wr_ch,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic [DATA_WIDTH-1:0] i_count,
    output logic                  o_equal
);

    logic [DATA_WIDTH-1:0] r_thr [NUM_CH];
    logic [DATA_WIDTH-1:0] w_thr;

    // Out-of-range write indices (non power-of-two NUM_CH) are dropped
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                r_thr[i] <= THR_RESET_VALUE[DATA_WIDTH-1:0];
            end
        end else if (i_wr_en) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (i_wr_ch == SEL_W'(i)) begin
                    r_thr[i] <= i_wr_data;
                end
            end
        end
    end

    always_comb begin
        w_thr = r_thr[0];
        for (int i = 1; i < NUM_CH; i++) begin
            if (i_sel == SEL_W'(i)) begin
                w_thr = r_thr[i];
            end
        end
    end

    // Compares against pre-edge contents, so a same-cycle write loses to a match
    assign o_equal = (i_count == w_thr);

endmodule : cmp_threshold_bank
`default_nettype wire

// File: rtl/timer_compare.sv
`default_nettype none
// ============================================================================
//  Module      : timer_compare
//  Description : Compare-match timer with periodic/one-shot modes, start/stop
//                control and channel-selected thresholds. Define
//                TIMER_PRESCALE_EN to divide the count tick by PRESC_DIV.
//  Revision    : 1.0 - initial release
// ============================================================================
module timer_compare
    import timer_cmp_pkg::*;
#(
    parameter  int DATA_WIDTH = 32,
    parameter  int NUM_CH     = 4,
    parameter  int PRESC_DIV  = 4,
    localparam int SEL_W      = $clog2(NUM_CH)
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_enable,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_mode,
    input  logic [SEL_W-1:0]      i_sel,
    input  logic                  i_wr_en,
    input  logic [SEL_W-1:0]      i_wr_ch,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic [DATA_WIDTH-1:0] o_count,
    output logic                  o_valid,
    output logic                  o_comp_reset,
    output logic [SEL_W-1:0]      o_match_ch,
    output logic                  o_busy
);

    state_t                r_state;
    logic [DATA_WIDTH-1:0] r_count;
    logic [SEL_W-1:0]      r_sel;
    logic                  r_mode;
    logic [SEL_W-1:0]      r_match_ch;
    logic                  r_valid;
    logic                  r_comp_reset;
    logic                  r_busy;

    state_t                w_state_nxt;
    logic [DATA_WIDTH-1:0] w_count_nxt;
    logic [SEL_W-1:0]      w_sel_nxt;
    logic                  w_mode_nxt;
    logic [SEL_W-1:0]      w_match_ch_nxt;
    logic                  w_pulse_nxt;
    logic                  w_tick;
    logic                  w_equal;
    logic                  w_match;

`ifdef TIMER_PRESCALE_EN
    localparam int PRESC_W = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;

    generate
        if (PRESC_DIV > 1) begin : g_presc
            logic [PRESC_W-1:0] r_presc;
            logic               w_presc_wrap;

            assign w_presc_wrap = (r_presc == PRESC_W'(PRESC_DIV - 1));

            // Restarting realigns the tick phase to the start pulse
            always_ff @(posedge i_clock) begin
                if (i_reset || i_start) begin
                    r_presc <= '0;
                end else if (i_enable) begin
                    r_presc <= w_presc_wrap ? '0 : r_presc + 1'b1;
                end
            end

            assign w_tick = i_enable && w_presc_wrap;
        end else begin : g_no_presc
            assign w_tick = i_enable;
        end
    endgenerate
`else
    localparam logic C_PRESC_OK = (PRESC_DIV >= 1);

    assign w_tick = i_enable & C_PRESC_OK;
`endif

    cmp_threshold_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .NUM_CH     (NUM_CH)
    ) u_thr_bank (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_wr_en   (i_wr_en),
        .i_wr_ch   (i_wr_ch),
        .i_wr_data (i_wr_data),
        .i_sel     (r_sel),
        .i_count   (r_count),
        .o_equal   (w_equal)
    );

    assign w_match = (r_state == ST_RUN) && w_tick && w_equal;

    // Priority: stop, then start/restart, then match, then plain count
    always_comb begin
        w_state_nxt    = r_state;
        w_count_nxt    = r_count;
        w_sel_nxt      = r_sel;
        w_mode_nxt     = r_mode;
        w_match_ch_nxt = r_match_ch;
        w_pulse_nxt    = 1'b0;

        if (i_stop) begin
            w_state_nxt = ST_IDLE;
        end else if (i_start) begin
            w_state_nxt = ST_RUN;
            w_count_nxt = '0;
            w_sel_nxt   = i_sel;
            w_mode_nxt  = i_mode;
        end else if (w_match) begin
            w_count_nxt    = '0;
            w_pulse_nxt    = 1'b1;
            w_match_ch_nxt = r_sel;
            w_sel_nxt      = i_sel;
            if (r_mode == MODE_ONESHOT) begin
                w_state_nxt = ST_DONE;
            end
        end else if ((r_state == ST_RUN) && w_tick) begin
            w_count_nxt = r_count + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_sel        <= '0;
            r_mode       <= MODE_PERIODIC;
            r_match_ch   <= '0;
            r_valid      <= 1'b0;
            r_comp_reset <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_count      <= w_count_nxt;
            r_sel        <= w_sel_nxt;
            r_mode       <= w_mode_nxt;
            r_match_ch   <= w_match_ch_nxt;
            r_valid      <= w_pulse_nxt;
            r_comp_reset <= w_pulse_nxt;
            r_busy       <= (w_state_nxt == ST_RUN);
        end
    end

    assign o_count      = r_count;
    assign o_valid      = r_valid;
    assign o_comp_reset = r_comp_reset;
    assign o_match_ch   = r_match_ch;
    assign o_busy       = r_busy;

endmodule : timer_compare
`default_nettype wire

// File: tb/tb_timer_compare.sv
`default_nettype none
// ============================================================================
//  Module      : tb_timer_compare
//  Description : Scenario bench for timer_compare on a 4-bit counter build.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_timer_compare;

    localparam int DW   = 4;
    localparam int NCH  = 4;
    localparam int SW   = $clog2(NCH);
    localparam int PDIV = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          start;
    logic          stop;
    logic          mode;
    logic [SW-1:0] sel;
    logic          wr_en;
    logic [SW-1:0] wr_ch;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] count;
    logic          valid;
    logic          comp_reset;
    logic [SW-1:0] match_ch;
    logic          busy;

    timer_compare #(
        .DATA_WIDTH (DW),
        .NUM_CH     (NCH),
        .PRESC_DIV  (PDIV)
    ) dut (
        .i_clock      (clk),
        .i_reset      (rst),
        .i_enable     (enable),
        .i_start      (start),
        .i_stop       (stop),
        .i_mode       (mode),
        .i_sel        (sel),
        .i_wr_en      (wr_en),
        .i_wr_ch      (wr_ch),
        .i_wr_data    (wr_data),
        .o_count      (count),
        .o_valid      (valid),
        .o_comp_reset (comp_reset),
        .o_match_ch   (match_ch),
        .o_busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] count;
        logic          valid;
        logic          comp;
        logic [SW-1:0] mch;
        logic          busy;
    } obs_t;

    obs_t exp_q[$];
    obs_t got;
    obs_t want;
    int   n_assert = 0;
    int   n_fail   = 0;

    function automatic obs_t mk(input int c, input bit v, input int ch, input bit b);
        obs_t o;
        o.count = DW'(c);
        o.valid = v;
        o.comp  = v;
        o.mch   = SW'(ch);
        o.busy  = b;
        return o;
    endfunction

    function automatic obs_t observe();
        obs_t o;
        o.count = count;
        o.valid = valid;
        o.comp  = comp_reset;
        o.mch   = match_ch;
        o.busy  = busy;
        return o;
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("cnt=%0d v=%0b cr=%0b ch=%0d busy=%0b",
                         o.count, o.valid, o.comp, o.mch, o.busy);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; start = 1'b0; stop = 1'b0; mode = 1'b0;
        sel = '0; wr_en = 1'b0; wr_ch = '0; wr_data = '0;
        step();
        rst = 1'b0;
    endtask

    task automatic write_thr(input int ch, input int val);
        wr_en = 1'b1; wr_ch = SW'(ch); wr_data = DW'(val);
        step();
        wr_en = 1'b0;
    endtask

    // Reset clears outputs even with start/write asserted; thresholds reset to 15
    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; start = 1'b1; stop = 1'b0; mode = 1'b0;
        sel = 2'd1; wr_en = 1'b1; wr_ch = 2'd0; wr_data = 4'd3;
        exp_q.push_back(mk(0, 0, 0, 0));
        step();
        want = exp_q.pop_front(); got = observe(); n_assert++;
        if (got !== want) begin
            n_fail++; $display("FAIL reset_outputs: got %s, expected %s", fmt(got), fmt(want));
        end
        rst = 1'b0; wr_en = 1'b0; sel = 2'd0;
        for (int k = 0; k <= 16; k++) begin
            start = (k == 0);
            exp_q.push_back(mk(k % 16, k == 16, 0, 1));
            step();
            want = exp_q.pop_front(); got = observe(); n_assert++;
            if (got !== want) begin
                n_fail++; $display("FAIL reset_thr_default[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_periodic();
        do_reset();
        write_thr(1, 3);
        enable = 1'b1; sel = 2'd1; mode = 1'b0;
        for (int k = 0; k <= 12; k++) begin
            start = (k == 0);
            exp_q.push_back(mk(k % 4, (k > 0) && (k % 4 == 0), (k >= 4) ? 1 : 0, 1));
            step();
            want = exp_q.pop_front(); got = observe(); n_assert++;
            if (got !== want) begin
                n_fail++; $display("FAIL periodic[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_oneshot();
        int cnt_t[14] = '{0, 1, 2, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0};
        do_reset();
        write_thr(0, 2);
        enable = 1'b1; sel = 2'd0; mode = 1'b1;
        for (int k = 0; k < 14; k++) begin
            start = (k == 0) || (k == 7);
            exp_q.push_back(mk(cnt_t[k], (k == 3) || (k == 10), 0,
                               (k < 3) || ((k >= 7) && (k < 10))));
            step();
            want = exp_q.pop_front(); got = observe(); n_assert++;
            if (got !== want) begin
                n_fail++; $display("FAIL oneshot[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
        start = 1'b0;
    endtask

    // Count only on enabled cycles; a stalled cycle at the threshold does not match
    task automatic test_enable_stop();
        bit en_t[10]  = '{1, 1, 0, 1, 0, 1, 1, 1, 1, 1};
        int cnt_t[10] = '{0, 1, 1, 2, 2, 0, 1, 1, 1, 1};
        do_reset();
        write_thr(2, 2);
        sel = 2'd2; mode = 1'b0;
        for (int k = 0; k < 10; k++) begin
            enable = en_t[k];
            start  = (k == 0) || (k == 7);
            stop   = (k == 7);
            exp_q.push_back(mk(cnt_t[k], k == 5, (k >= 5) ? 2 : 0, k < 7));
            step();
            want = exp_q.pop_front(); got = observe(); n_assert++;
            if (got !== want) begin
                n_fail++; $display("FAIL enable_stop[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
        start = 1'b0; stop = 1'b0;
    endtask

    // Lower the threshold below count (forces wrap), then write during a match
    task automatic test_threshold_write();
        int  c;
        bit  v;
        do_reset();
        write_thr(0, 10);
        enable = 1'b1; sel = 2'd0; mode = 1'b0;
        for (int k = 0; k <= 36; k++) begin
            start   = (k == 0);
            wr_en   = (k == 7) || (k == 26);
            wr_ch   = 2'd0;
            wr_data = (k == 7) ? 4'd4 : 4'd9;
            v = (k == 21) || (k == 26) || (k == 36);
            if (k <= 20)      c = k % 16;
            else if (k <= 25) c = k - 21;
            else              c = k - 26;
            if (k == 36) c = 0;
            exp_q.push_back(mk(c, v, 0, 1));
            step();
            want = exp_q.pop_front(); got = observe(); n_assert++;
            if (got !== want) begin
                n_fail++; $display("FAIL thr_write[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
        start = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_sel_reset();
        int c;
        int ch;
        bit v;
        do_reset();
        write_thr(0, 3);
        write_thr(2, 5);
        enable = 1'b1; sel = 2'd0; mode = 1'b0;
        for (int k = 0; k <= 18; k++) begin
            start = (k == 0);
            if (k == 2) sel = 2'd2;
            rst = (k == 16);
            v = (k == 4) || (k == 10);
            if (k <= 3)       begin c = k;      ch = 0; end
            else if (k == 4)  begin c = 0;      ch = 0; end
            else if (k <= 9)  begin c = k - 4;  ch = 0; end
            else if (k == 10) begin c = 0;      ch = 2; end
            else if (k <= 15) begin c = k - 10; ch = 2; end
            else              begin c = 0;      ch = 0; end
            exp_q.push_back(mk(c, v, ch, k < 16));
            step();
            want = exp_q.pop_front(); got = observe(); n_assert++;
            if (got !== want) begin
                n_fail++; $display("FAIL sel_reset[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
        rst = 1'b0; start = 1'b0;
    endtask

    // thr=0 pulses on every tick; then restart mid-count and stop
    task automatic test_back_to_back();
        int cnt_t[16] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, 3, 0, 1, 2, 2};
        do_reset();
        write_thr(1, 0);
        sel = 2'd1; mode = 1'b0;
        for (int k = 0; k < 16; k++) begin
            enable  = (k != 5);
            start   = (k == 0) || (k == 12);
            stop    = (k == 15);
            wr_en   = (k == 8);
            wr_ch   = 2'd1;
            wr_data = 4'd6;
            if (k == 12) begin sel = 2'd3; mode = 1'b1; end
            exp_q.push_back(mk(cnt_t[k], (k >= 1) && (k <= 8) && (k != 5),
                               (k >= 1) ? 1 : 0, k != 15));
            step();
            want = exp_q.pop_front(); got = observe(); n_assert++;
            if (got !== want) begin
                n_fail++; $display("FAIL back_to_back[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
        start = 1'b0; stop = 1'b0; wr_en = 1'b0;
    endtask

    task automatic test_prescale();
        do_reset();
        exp_q.push_back(mk(0, 0, 0, 0));
        step();
        want = exp_q.pop_front(); got = observe(); n_assert++;
        if (got !== want) begin
            n_fail++; $display("FAIL prescale_reset: got %s, expected %s", fmt(got), fmt(want));
        end
        write_thr(0, 1);
        enable = 1'b1; sel = 2'd0; mode = 1'b0;
        for (int k = 0; k <= 24; k++) begin
            start = (k == 0);
            exp_q.push_back(mk(((k % 8) >= 4) ? 1 : 0, (k > 0) && (k % 8 == 0), 0, 1));
            step();
            want = exp_q.pop_front(); got = observe(); n_assert++;
            if (got !== want) begin
                n_fail++; $display("FAIL prescale[%0d]: got %s, expected %s", k, fmt(got), fmt(want));
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
`ifdef TIMER_PRESCALE_EN
        test_prescale();
`else
        test_reset();
        test_periodic();
        test_oneshot();
        test_enable_stop();
        test_threshold_write();
        test_sel_reset();
        test_back_to_back();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_timer_compare
`default_nettype wire
